// File: rtl/console_samp_sched.sv
// console_samp_sched: acquisition scheduler between the sample-tick generator,
// the ADC collection ports and the frame packer.
//
// Build option: define CONSOLE_SCHED_TIMEOUT_EN to include the per-ADC wait
// limit (16-bit counter plus sticky err_timeout flags). Without it the
// scheduler waits on each adc_fd indefinitely and err_timeout reads 0.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | disabled; idx/timer cleared, rate code latched on exit
// WAIT  | enabled, waiting for a sample tick
// ACK   | one-cycle tick acknowledge, start at port 0
// ADC   | adc_fs[idx] high, waiting for adc_fd[idx] (or the wait limit)
// NEXT  | gap cycle between ports; advance idx or move on to PACK
// PACK  | pack_fs high until the packer takes the frame
// DONE  | frame boundary; new rate code latched, back to WAIT
module console_samp_sched #(
    parameter int unsigned NUM_ADC = 4,
    parameter logic [15:0] TIMEOUT = 16'd40_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               work,
    input  logic [3:0]         freq_in,
    output logic [3:0]         freq_samp,
    input  logic               tick_fs,
    output logic               tick_fd,
    output logic [NUM_ADC-1:0] adc_fs,
    input  logic [NUM_ADC-1:0] adc_fd,
    output logic               pack_fs,
    input  logic               pack_fd,
    output logic [NUM_ADC-1:0] err_timeout,
    output logic [7:0]         overrun_cnt,
    output logic               busy
);

    localparam int unsigned      IDX_W    = (NUM_ADC > 1) ? $clog2(NUM_ADC) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ADC - 1);

    typedef enum logic [6:0] {
        IDLE = 7'b000_0001,
        WAIT = 7'b000_0010,
        ACK  = 7'b000_0100,
        ADC  = 7'b000_1000,
        NEXT = 7'b001_0000,
        PACK = 7'b010_0000,
        DONE = 7'b100_0000
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       freq_q, freq_d;
    logic             tick_q;
    logic [7:0]       ovr_q, ovr_d;
    logic             tick_rise;
    logic             tmo_hit;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping work abandons whatever is in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (work) state_d = WAIT;
            WAIT: if (tick_fs) state_d = ACK;
            ACK:  state_d = ADC;
            ADC:  if (adc_fd[idx_q] || tmo_hit) state_d = NEXT;
            NEXT: state_d = (idx_q == IDX_LAST) ? PACK : ADC;
            PACK: if (pack_fd) state_d = DONE;
            DONE: state_d = WAIT;
            default: state_d = IDLE;
        endcase
        if (!work) begin
            state_d = IDLE;
        end
    end

    // Handshake outputs decode purely from the current state.
    always_comb begin
        tick_fd = (state_q == ACK);
        pack_fs = (state_q == PACK);
        busy    = !((state_q == IDLE) || (state_q == WAIT));
        adc_fs  = '0;
        if (state_q == ADC) begin
            adc_fs[idx_q] = 1'b1;
        end
    end

    // Port index: restarts at 0 for every frame, steps in NEXT.
    always_comb begin
        idx_d = idx_q;
        if ((state_q == IDLE) || (state_q == ACK)) begin
            idx_d = '0;
        end else if ((state_q == NEXT) && (idx_q != IDX_LAST)) begin
            idx_d = idx_q + 1'b1;
        end
    end

    // Rate code follows freq_in only on the edges leaving IDLE or DONE.
    always_comb begin
        freq_d = freq_q;
        if (((state_q == IDLE) && work) || (state_q == DONE)) begin
            freq_d = freq_in;
        end
    end

    // A tick rising outside WAIT was missed; count it, saturating.
    assign tick_rise = tick_fs && !tick_q;

    always_comb begin
        ovr_d = ovr_q;
        if (!work) begin
            ovr_d = '0;
        end else if (tick_rise && (state_q != WAIT) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end
    end

    // Index, rate code and overrun bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            freq_q <= 4'h1;
            tick_q <= 1'b0;
            ovr_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            freq_q <= freq_d;
            tick_q <= tick_fs;
            ovr_q  <= ovr_d;
        end
    end

    assign freq_samp   = freq_q;
    assign overrun_cnt = ovr_q;

`ifdef CONSOLE_SCHED_TIMEOUT_EN
    logic [15:0]        tmo_q, tmo_d;
    logic [NUM_ADC-1:0] err_q, err_d;

    // Counter only runs while a port is being polled; any other state clears it.
    assign tmo_hit = (tmo_q == (TIMEOUT - 16'd1));

    // Wait-limit counter next value and sticky per-port flags (fd wins a tie).
    always_comb begin
        tmo_d = '0;
        if (state_q == ADC) begin
            tmo_d = tmo_q + 16'd1;
        end
        err_d = err_q;
        if (!work) begin
            err_d = '0;
        end else if ((state_q == ADC) && tmo_hit && !adc_fd[idx_q]) begin
            err_d[idx_q] = 1'b1;
        end
    end

    // Wait-limit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= '0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    logic unused_timeout;

    assign tmo_hit        = 1'b0;
    assign err_timeout    = '0;
    assign unused_timeout = ^TIMEOUT;
`endif

endmodule

// File: doc/console_samp_sched.md
# console_samp_sched

Acquisition scheduler between the console sample-tick generator and the ADC collection ports. On each sample tick it acknowledges the tick generator and polls each ADC port in turn with an fs/fd handshake. It then hands the completed frame to the packer. It owns the sample-rate setting given to the tick generator, applies rate changes only at frame boundaries, and reports overruns and ADC timeouts.

## Interface
Parameters:
- NUM_ADC, 4: number of ADC ports, 1..8.
- TIMEOUT, 16'd40_000: per-ADC wait limit in clk cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- work  in  1  enable; low forces the block back to IDLE synchronously.
- freq_in  in  4  requested rate code (1=1k, 2=2k, 3=4k, 4=8k, 5=16k).
- freq_samp  out  4  rate code driven to the tick generator.
- tick_fs  in  1  sample tick, a level held until acknowledged.
- tick_fd  out  1  tick acknowledge, one-cycle pulse.
- adc_fs  out  NUM_ADC  per-port start, a level.
- adc_fd  in  NUM_ADC  per-port done.
- pack_fs  out  1  frame ready for the packer, a level.
- pack_fd  in  1  packer accepted the frame.
- err_timeout  out  NUM_ADC  sticky per-port timeout flags.
- overrun_cnt  out  8  count of missed tick edges, saturating.
- busy  out  1  high in every state except IDLE and WAIT.

## Operation
- The FSM has one-hot states IDLE, WAIT, ACK, ADC, NEXT, PACK, DONE. The state register is the only sequential control; all handshake outputs decode from state (Moore).
- IDLE:
  - Clear idx and the timeout counter; load freq_samp <= freq_in.
  - Go to WAIT when work=1.
- WAIT: go to ACK when tick_fs=1.
- ACK:
  - Drive tick_fd=1 for exactly one cycle.
  - Set idx=0 and go to ADC.
- ADC:
  - Drive adc_fs[idx]=1; all other adc_fs bits are 0.
  - If adc_fd[idx]=1, go to NEXT.
  - Else, if the timeout counter equals TIMEOUT-1, set err_timeout[idx] and go to NEXT.
  - adc_fd bits other than idx are ignored.
- NEXT:
  - Clear the timeout counter; adc_fs is 0.
  - If idx==NUM_ADC-1, go to PACK; else idx++ and go to ADC.
- PACK: drive pack_fs=1 until pack_fd=1, then go to DONE. There is no timeout on the packer.
- DONE:
  - Frame boundary: freq_samp <= freq_in.
  - Go to WAIT.
- Overrun:
  - A registered edge detector on tick_fs flags a rising edge seen while state is not WAIT.
  - Each such edge increments overrun_cnt; the count saturates at 8'hFF.
  - The tick is not dropped: if tick_fs is still high when WAIT is reached, it is serviced normally.
- work=0 in any state:
  - Next state is IDLE and all fs outputs drop on the next edge.
  - err_timeout and overrun_cnt clear.
  - A frame in progress is abandoned without a pack_fs.
- idx width is $clog2(NUM_ADC) with a minimum of 1. The timeout counter is 16 bits and counts only in ADC.

## Timing
- Reset values: freq_samp=4'h1; every other output is 0; state=IDLE.
- tick_fs is high at edge T with the block in WAIT:
  - tick_fd=1 in cycle T+1 (ACK).
  - adc_fs[0]=1 from T+2.
- Per ADC port:
  - adc_fd[i] is sampled high at edge E.
  - adc_fs[i] falls at E+1 (NEXT).
  - adc_fs[i+1] rises at E+2.
- Frame latency is 3 cycles plus the sum over ports of (fd delay + 2), plus pack_fs to pack_fd, plus 1 (DONE).
- With adc_fd never asserted, adc_fs[idx] stays high for exactly TIMEOUT cycles.
- If adc_fd[idx] rises in the same cycle the counter hits TIMEOUT-1, fd wins: err_timeout is not set.
- freq_samp changes only on the edge leaving IDLE or DONE. A freq_in change mid-frame takes effect one cycle after pack_fd.

## Configuration
- CONSOLE_SCHED_TIMEOUT_EN defined: ADC timeout logic, the 16-bit counter and err_timeout are present as described above.
- Undefined:
  - ADC waits indefinitely for adc_fd.
  - The counter is removed and err_timeout is tied to 0.
  - The TIMEOUT parameter is unused.

## Test plan
- NUM_ADC=4, each adc_fd answering 3 cycles after adc_fs, pack_fd 2 cycles after pack_fs, one tick → tick_fd one pulse, adc_fs 1,2,4,8 in order, pack_fs once, freq_samp=1.
- Timeout enabled, TIMEOUT=16, port 2 silent → adc_fs[2] high exactly 16 cycles, err_timeout=4'b0100, frame completes with pack_fs.
- tick_fs pulses 3 times while stalled in PACK (pack_fd held low) → overrun_cnt=3; pending tick serviced on return to WAIT.
- freq_in changed 1→5 during ADC phase → freq_samp stays 1 until the edge after DONE, then 5.
- work dropped mid-ADC with err_timeout=4'b0001, overrun_cnt=2 → next cycle IDLE, adc_fs=0, err_timeout=0, overrun_cnt=0; no pack_fs.
- Timeout disabled, adc_fd held low 100k cycles → adc_fs stays high, err_timeout=0; async rst mid-frame → all outputs at reset values immediately.
